logic_op_scheduler: RTL and testbench

- Round-robin controller that shares one registered logic unit between two requesters. The logic unit is 8-bit in, 16-bit out, with a 2-bit select and an enable.
- Accepts operation requests over valid/ready, issues each one to the unit, and captures the unit's 1-cycle-latency result.
- Returns each result, tagged with the requester id, through a single-entry output buffer with backpressure.
- Sits between the ALU front-end request sources and the logic unit instance.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/logic_op_scheduler_rr_arb2.sv | 24 ++
 rtl/logic_op_scheduler.sv | 115 +++++++++++
 tb/tb_logic_op_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the logic-unit scheduler and its arbiter.
package alu_pkg;

    // Logic unit select encodings
    localparam logic [1:0] LU_OP_AND = 2'b00;
    localparam logic [1:0] LU_OP_OR  = 2'b01;
    localparam logic [1:0] LU_OP_XOR = 2'b10;
    localparam logic [1:0] LU_OP_NOT = 2'b11;

    // Default datapath widths of the shared logic unit
    localparam int LU_DATA_W = 8;
    localparam int LU_RES_W  = 16;

    // Scheduler FSM encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/logic_op_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: the requester at ptr has priority, the other
// requester wins only when the priority one is idle. Purely combinational.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    // Pick the winner, favouring the requester the pointer names
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt    = 2'b00;
        gnt_id = ptr;
        if (req[ptr]) begin
            gnt[ptr] = 1'b1;
            gnt_id   = ptr;
        end else if (req[~ptr]) begin
            gnt[~ptr] = 1'b1;
            gnt_id    = ~ptr;
        end
    end

endmodule

// File: rtl/logic_op_scheduler.sv
// Shares one registered logic unit between two requesters. Requests are
// arbitrated round-robin, issued for one cycle, the 1-cycle-latency result
// captured, and returned through a single-entry buffer with backpressure.
module logic_op_scheduler
    import alu_pkg::*;
#(
    parameter int DATA_W = LU_DATA_W,
    parameter int RES_W  = LU_RES_W,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*DATA_W-1:0]   req_a,
    input  logic [2*DATA_W-1:0]   req_b,
    input  logic [3:0]            req_op,
    output logic [DATA_W-1:0]     lu_a,
    output logic [DATA_W-1:0]     lu_b,
    output logic [1:0]            lu_s,
    output logic                  lu_en,
    input  logic [RES_W-1:0]      lu_out,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [RES_W-1:0]      res_data,
    output logic                  res_id,
    output logic                  busy,
    output logic [CNT_W-1:0]      ops_done
);

    sched_state_t      state, state_next;
    logic              rr_ptr;
    logic              gnt_id;
    logic [1:0]        arb_gnt;
    logic              arb_id;
    logic              grant;
    logic [DATA_W-1:0] iss_a, iss_b;
    logic [1:0]        iss_s;

    rr_arb2 u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .gnt    (arb_gnt),
        .gnt_id (arb_id)
    );

    // A grant only takes effect while idle; otherwise requesters see no ready
    assign grant     = (state == IDLE) && (arb_gnt != 2'b00);
    assign req_ready = (state == IDLE) ? arb_gnt : 2'b00;

    // The unit is enabled only in ISSUE; operands hold their last issued values
    assign lu_en = (state == ISSUE);
    assign lu_a  = iss_a;
    assign lu_b  = iss_b;
    assign lu_s  = iss_s;
    assign busy  = (state != IDLE);

    // Next-state logic for the issue/wait/respond sequence
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (grant) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = RESP;
            RESP:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Latch the winning request's payload and advance the round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_a  <= '0;
            iss_b  <= '0;
            iss_s  <= LU_OP_AND;
            gnt_id <= 1'b0;
            rr_ptr <= 1'b0;
        end else if (grant) begin
            iss_a  <= arb_id ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
            iss_b  <= arb_id ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
            iss_s  <= arb_id ? req_op[3:2] : req_op[1:0];
            gnt_id <= arb_id;
            rr_ptr <= ~arb_id;
        end
    end

    // Capture the unit result in WAIT, release it on the consumer handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
            ops_done  <= '0;
        end else begin
            if (state == WAIT) begin
                // lu_out is only meaningful here: the unit clears it once en drops
                res_data  <= lu_out;
                res_id    <= gnt_id;
                res_valid <= 1'b1;
            end
            if (state == RESP && res_ready) begin
                res_valid <= 1'b0;
                ops_done  <= ops_done + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Directed bench for logic_op_scheduler with a behavioural logic unit on lu_*.
module tb_logic_op_scheduler;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [15:0]      req_a;
    logic [15:0]      req_b;
    logic [3:0]       req_op;
    logic [7:0]       lu_a;
    logic [7:0]       lu_b;
    logic [1:0]       lu_s;
    logic             lu_en;
    logic [15:0]      lu_out;
    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_data;
    logic             res_id;
    logic             busy;
    logic [CNT_W-1:0] ops_done;

    int total = 0;
    int bad   = 0;
    int exp_ops = 0;

    logic_op_scheduler #(.DATA_W(8), .RES_W(16), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .lu_a      (lu_a),
        .lu_b      (lu_b),
        .lu_s      (lu_s),
        .lu_en     (lu_en),
        .lu_out    (lu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    // Registered logic unit: result one cycle after en, cleared when en is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         lu_out <= 16'h0000;
        else if (!lu_en) lu_out <= 16'h0000;
        else begin
            case (lu_s)
                2'b00:   lu_out <= {8'h00, lu_a & lu_b};
                2'b01:   lu_out <= {8'h00, lu_a | lu_b};
                2'b10:   lu_out <= {8'h00, lu_a ^ lu_b};
                default: lu_out <= ~{8'h00, lu_a};
            endcase
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request on requester id and follow it to its handshake
    task automatic run_op(input bit id, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] op, input logic [15:0] exp);
        int n;
        req_a[id*8 +: 8]  = a;
        req_b[id*8 +: 8]  = b;
        req_op[id*2 +: 2] = op;
        req_valid[id]     = 1'b1;
        res_ready         = 1'b1;
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
        total++; if (req_ready !== (2'b01 << id)) begin bad++; $display("FAIL op_ready: got %b want %b", req_ready, 2'b01 << id); end
        @(negedge clk);
        req_valid[id] = 1'b0;
        n = 0;
        while (res_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL op_res_valid_timeout: got %b want 1", res_valid); end
        total++; if (res_data !== exp) begin bad++; $display("FAIL op_data: got %h want %h", res_data, exp); end
        total++; if (res_id !== id) begin bad++; $display("FAIL op_id: got %b want %b", res_id, id); end
        @(negedge clk);
        exp_ops++;
        total++; if (ops_done !== CNT_W'(exp_ops)) begin bad++; $display("FAIL op_count: got %0d want %0d", ops_done, CNT_W'(exp_ops)); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL op_res_clear: got %b want 0", res_valid); end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b00; req_a = '0; req_b = '0; req_op = '0; res_ready = 1'b0;
        #1;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready: got %b want 00", req_ready); end
        total++; if (lu_en !== 1'b0) begin bad++; $display("FAIL rst_lu_en: got %b want 0", lu_en); end
        total++; if ({lu_a, lu_b, lu_s} !== 18'h0) begin bad++; $display("FAIL rst_lu_bus: got %h want 0", {lu_a, lu_b, lu_s}); end
        total++; if ({res_valid, res_data, res_id} !== 18'h0) begin bad++; $display("FAIL rst_res: got %h want 0", {res_valid, res_data, res_id}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (ops_done !== '0) begin bad++; $display("FAIL rst_ops: got %0d want 0", ops_done); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_ops = 0;
        @(negedge clk);
    endtask

    task automatic test_single_and();
        req_a[7:0] = 8'hF0; req_b[7:0] = 8'h3C; req_op[1:0] = 2'b00;
        req_valid = 2'b01; res_ready = 1'b1;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL and_ready: got %b want 01", req_ready); end
        @(negedge clk); req_valid = 2'b00; #1;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL and_ready_one_cycle: got %b want 00", req_ready); end
        total++; if (lu_en !== 1'b1) begin bad++; $display("FAIL and_issue_en: got %b want 1", lu_en); end
        total++; if ({lu_a, lu_b, lu_s} !== {8'hF0, 8'h3C, 2'b00}) begin bad++; $display("FAIL and_issue_bus: got %h want %h", {lu_a, lu_b, lu_s}, {8'hF0, 8'h3C, 2'b00}); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL and_busy: got %b want 1", busy); end
        @(negedge clk);
        total++; if (lu_en !== 1'b0) begin bad++; $display("FAIL and_wait_en: got %b want 0", lu_en); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL and_early_valid: got %b want 0", res_valid); end
        @(negedge clk);
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL and_valid_latency: got %b want 1", res_valid); end
        total++; if (res_data !== 16'h0030) begin bad++; $display("FAIL and_data: got %h want 0030", res_data); end
        total++; if (res_id !== 1'b0) begin bad++; $display("FAIL and_id: got %b want 0", res_id); end
        @(negedge clk);
        exp_ops++;
        total++; if (ops_done !== CNT_W'(1)) begin bad++; $display("FAIL and_count: got %0d want 1", ops_done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL and_idle: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int n;
        bit exp_id;
        logic [15:0] exp_data;
        rst = 1'b1; #1; rst = 1'b0; exp_ops = 0;
        @(negedge clk);
        req_a = {8'h01, 8'hAA}; req_b = {8'h80, 8'h55}; req_op = {2'b01, 2'b10};
        req_valid = 2'b11; res_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_id   = i[0];
            exp_data = exp_id ? 16'h0081 : 16'h00FF;
            n = 0;
            while (req_ready == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
            total++; if (req_ready !== (2'b01 << exp_id)) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, 2'b01 << exp_id); end
            @(negedge clk);
            if (i == 3) req_valid = 2'b00;
            n = 0;
            while (res_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
            total++; if (res_data !== exp_data) begin bad++; $display("FAIL rr_data%0d: got %h want %h", i, res_data, exp_data); end
            total++; if (res_id !== exp_id) begin bad++; $display("FAIL rr_id%0d: got %b want %b", i, res_id, exp_id); end
            @(negedge clk); #1;
            exp_ops++;
            total++; if (ops_done !== CNT_W'(exp_ops)) begin bad++; $display("FAIL rr_count%0d: got %0d want %0d", i, ops_done, CNT_W'(exp_ops)); end
        end
    endtask

    task automatic test_not();
        run_op(1'b1, 8'h0F, 8'h00, 2'b11, 16'hFFF0);
    endtask

    task automatic test_backpressure();
        int n;
        int base;
        req_a[7:0] = 8'h3C; req_b[7:0] = 8'h0F; req_op[1:0] = 2'b01;
        req_valid = 2'b01; res_ready = 1'b0;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL bp_ready: got %b want 01", req_ready); end
        @(negedge clk);
        req_a[15:8] = 8'hF0; req_op[3:2] = 2'b11; req_valid = 2'b10;
        n = 0;
        while (res_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        base = exp_ops;
        for (int i = 0; i < 10; i++) begin
            total++; if ({res_valid, res_data, res_id} !== {1'b1, 16'h003F, 1'b0}) begin bad++; $display("FAIL bp_hold%0d: got %h want %h", i, {res_valid, res_data, res_id}, {1'b1, 16'h003F, 1'b0}); end
            total++; if ({req_ready, busy} !== 3'b001) begin bad++; $display("FAIL bp_block%0d: got %b want 001", i, {req_ready, busy}); end
            total++; if (ops_done !== CNT_W'(base)) begin bad++; $display("FAIL bp_count%0d: got %0d want %0d", i, ops_done, CNT_W'(base)); end
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk); #1;
        exp_ops++;
        total++; if (ops_done !== CNT_W'(exp_ops)) begin bad++; $display("FAIL bp_release_count: got %0d want %0d", ops_done, CNT_W'(exp_ops)); end
        total++; if ({busy, res_valid} !== 2'b00) begin bad++; $display("FAIL bp_release_idle: got %b want 00", {busy, res_valid}); end
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL bp_pending: got %b want 10", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        n = 0;
        while (res_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        total++; if ({res_data, res_id} !== {16'hFF0F, 1'b1}) begin bad++; $display("FAIL bp_next: got %h want %h", {res_data, res_id}, {16'hFF0F, 1'b1}); end
        @(negedge clk);
        exp_ops++;
        total++; if (ops_done !== CNT_W'(exp_ops)) begin bad++; $display("FAIL bp_next_count: got %0d want %0d", ops_done, CNT_W'(exp_ops)); end
    endtask

    task automatic test_reset_mid_op();
        req_a[7:0] = 8'hFF; req_b[7:0] = 8'h0F; req_op[1:0] = 2'b00;
        req_valid = 2'b01; res_ready = 1'b1;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL mid_ready: got %b want 01", req_ready); end
        @(negedge clk); req_valid = 2'b00;
        @(negedge clk);
        total++; if ({lu_en, busy} !== 2'b01) begin bad++; $display("FAIL mid_in_wait: got %b want 01", {lu_en, busy}); end
        rst = 1'b1; #1;
        total++; if ({lu_en, res_valid, busy} !== 3'b000) begin bad++; $display("FAIL mid_async: got %b want 000", {lu_en, res_valid, busy}); end
        total++; if (ops_done !== '0) begin bad++; $display("FAIL mid_count: got %0d want 0", ops_done); end
        @(negedge clk); rst = 1'b0; exp_ops = 0;
        repeat (3) @(negedge clk);
        total++; if ({res_valid, busy} !== 2'b00) begin bad++; $display("FAIL mid_no_stale: got %b want 00", {res_valid, busy}); end
        run_op(1'b0, 8'hF0, 8'h3C, 2'b00, 16'h0030);
    endtask

    task automatic test_wrap();
        logic [7:0]  ta [4] = '{8'hF0, 8'h0F, 8'hAA, 8'h01};
        logic [7:0]  tb [4] = '{8'h3C, 8'h00, 8'h55, 8'h80};
        logic [1:0]  to [4] = '{2'b00, 2'b11, 2'b10, 2'b01};
        logic [15:0] te [4] = '{16'h0030, 16'hFFF0, 16'h00FF, 16'h0081};
        for (int i = 0; i < 15; i++) begin
            run_op(i[0], ta[i%4], tb[i%4], to[i%4], te[i%4]);
        end
        total++; if (ops_done !== '0) begin bad++; $display("FAIL wrap_zero: got %0d want 0", ops_done); end
    endtask

    initial begin
        test_reset();
        test_single_and();
        test_round_robin();
        test_not();
        test_backpressure();
        test_reset_mid_op();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
